// File: rtl/rb_pkg.sv
// Shared types and sizes for the register-bank read path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rb_pkg;
    localparam int RB_WIDTH = 16;
    localparam int RB_DEPTH = 8;
    localparam int RB_SEL_W = 3;

    typedef logic [RB_WIDTH-1:0] rb_word_t;
    typedef logic [RB_SEL_W-1:0] rb_idx_t;
endpackage

// File: rtl/rb_mux_core.sv
// Combinational NUM_IN:1 word selector with an out-of-range flag.
// Latency: zero cycles, purely combinational.
// Backpressure: none; no handshake, output always valid.
module rb_mux_core
    import rb_pkg::*;
#(
    parameter int WIDTH  = RB_WIDTH,
    parameter int NUM_IN = RB_DEPTH,
    parameter int SEL_W  = RB_SEL_W
) (
    input  logic [RB_DEPTH-1:0][WIDTH-1:0] words,
    input  logic [SEL_W-1:0]               sel,
    output logic [WIDTH-1:0]               out,
    output logic                           sel_err
);

    // Equality match per slot: an unknown sel matches nothing and reads as zero,
    // and slots at or above NUM_IN can never be selected.
    always_comb begin
        out = '0;
        for (int i = 0; i < RB_DEPTH; i++) begin
            if ((i < NUM_IN) && (sel == SEL_W'(i))) begin
                out = words[i];
            end
        end
    end

    assign sel_err = (int'(sel) >= NUM_IN);

endmodule

// File: rtl/rb_read_mux.sv
// Register-bank read port: combinational selected word plus a registered copy.
// Latency: out is zero-cycle; out_q is exactly one cycle behind out.
// Backpressure: none; no handshake or enable, out_q captures every edge.
module rb_read_mux
    import rb_pkg::*;
#(
    parameter int WIDTH  = RB_WIDTH,
    parameter int NUM_IN = RB_DEPTH,
    parameter int SEL_W  = RB_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_err
);

    logic [RB_DEPTH-1:0][WIDTH-1:0] words;

    assign words = {in7, in6, in5, in4, in3, in2, in1, in0};

    rb_mux_core #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_core (
        .words   (words),
        .sel     (sel),
        .out     (out),
        .sel_err (sel_err)
    );

    // Reset only clears the registered copy; the combinational path keeps tracking sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out;
        end
    end

endmodule

// File: tb/tb_rb_read_mux.sv
// Scoreboard bench for rb_read_mux: default 8-input instance plus a 6-input instance.
module tb_rb_read_mux;
    import rb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] in_w [8];
    logic [2:0]  sel;
    logic [2:0]  sel6;
    logic [15:0] out, out_q, out6, out_q6;
    logic        sel_err, sel_err6;

    logic [15:0] sb [$];
    logic [15:0] exp_v;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    rb_read_mux dut (
        .clk(clk), .rst_n(rst_n),
        .in0(in_w[0]), .in1(in_w[1]), .in2(in_w[2]), .in3(in_w[3]),
        .in4(in_w[4]), .in5(in_w[5]), .in6(in_w[6]), .in7(in_w[7]),
        .sel(sel), .out(out), .out_q(out_q), .sel_err(sel_err)
    );

    rb_read_mux #(.WIDTH(16), .NUM_IN(6), .SEL_W(3)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in0(in_w[0]), .in1(in_w[1]), .in2(in_w[2]), .in3(in_w[3]),
        .in4(in_w[4]), .in5(in_w[5]), .in6(in_w[6]), .in7(in_w[7]),
        .sel(sel6), .out(out6), .out_q(out_q6), .sel_err(sel_err6)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        for (int k = 0; k < 8; k++) in_w[k] = 16'(k);
        sel  = 3'd6;
        sel6 = 3'd0;
        #2 rst_n = 1'b0;
        #1;
        sb.push_back(16'h0000);
        exp_v = sb.pop_front();
        n_vec++;
        if (out_q !== exp_v) begin
            $display("FAIL reset_async out_q=%h expected=%h", out_q, exp_v); n_err++;
        end
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(16'h0000);
        sb.push_back(16'h0006);
        exp_v = sb.pop_front();
        n_vec++;
        if (out_q !== exp_v) begin
            $display("FAIL reset_hold out_q=%h expected=%h", out_q, exp_v); n_err++;
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (out !== exp_v) begin
            $display("FAIL reset_out_comb out=%h expected=%h", out, exp_v); n_err++;
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        n_vec++;
        if (out_q !== 16'h0000) begin
            $display("FAIL reset_release_noedge out_q=%h expected=0000", out_q); n_err++;
        end
        sb.push_back(16'h0006);
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        n_vec++;
        if (out_q !== exp_v) begin
            $display("FAIL reset_first_capture out_q=%h expected=%h", out_q, exp_v); n_err++;
        end
    endtask

    task automatic test_sweep();
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            sb.push_back(16'(s));
            #1;
            exp_v = sb.pop_front();
            n_vec++;
            if (out !== exp_v || sel_err !== 1'b0) begin
                $display("FAIL sweep sel=%0d out=%h err=%b expected=%h err=0", s, out, sel_err, exp_v);
                n_err++;
            end
            #99;
        end
    endtask

    task automatic test_mid_cycle();
        @(negedge clk) sel = 3'd2;
        sb.push_back(16'h0002);
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        n_vec++;
        if (out_q !== exp_v) begin
            $display("FAIL mid_cycle_q2 out_q=%h expected=%h", out_q, exp_v); n_err++;
        end
        @(negedge clk) sel = 3'd5;
        sb.push_back(16'h0005);
        sb.push_back(16'h0002);
        sb.push_back(16'h0005);
        #1;
        exp_v = sb.pop_front();
        n_vec++;
        if (out !== exp_v) begin
            $display("FAIL mid_cycle_out out=%h expected=%h", out, exp_v); n_err++;
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (out_q !== exp_v) begin
            $display("FAIL mid_cycle_q_hold out_q=%h expected=%h", out_q, exp_v); n_err++;
        end
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        n_vec++;
        if (out_q !== exp_v) begin
            $display("FAIL mid_cycle_q5 out_q=%h expected=%h", out_q, exp_v); n_err++;
        end
    endtask

    task automatic test_reset_mid();
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_q !== 16'h0000 || out !== 16'h0005) begin
            $display("FAIL reset_mid out_q=%h out=%h expected out_q=0000 out=0005", out_q, out); n_err++;
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (out_q !== 16'h0000 || out !== 16'h0005) begin
            $display("FAIL reset_mid_hold out_q=%h out=%h expected out_q=0000 out=0005", out_q, out); n_err++;
        end
        @(negedge clk) rst_n = 1'b1;
        sb.push_back(16'h0005);
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        n_vec++;
        if (out_q !== exp_v) begin
            $display("FAIL reset_mid_release out_q=%h expected=%h", out_q, exp_v); n_err++;
        end
    endtask

    task automatic test_in_change();
        @(negedge clk) sel = 3'd3;
        #1 in_w[3] = 16'hBEEF;
        sb.push_back(16'hBEEF);
        sb.push_back(16'hBEEF);
        #0;
        exp_v = sb.pop_front();
        n_vec++;
        if (out !== exp_v) begin
            $display("FAIL in_change_out out=%h expected=%h", out, exp_v); n_err++;
        end
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        n_vec++;
        if (out_q !== exp_v) begin
            $display("FAIL in_change_q out_q=%h expected=%h", out_q, exp_v); n_err++;
        end
        @(negedge clk) in_w[4] = 16'h1234;
        #1;
        n_vec++;
        if (out !== 16'hBEEF) begin
            $display("FAIL unselected_change out=%h expected=beef", out); n_err++;
        end
    endtask

    task automatic test_num_in6();
        for (int s = 0; s < 8; s++) begin
            @(negedge clk) sel6 = 3'(s);
            sb.push_back((s < 6) ? in_w[s] : 16'h0000);
            #1;
            exp_v = sb.pop_front();
            n_vec++;
            if (out6 !== exp_v || sel_err6 !== (s >= 6)) begin
                $display("FAIL num_in6 sel=%0d out=%h err=%b expected=%h err=%0d", s, out6, sel_err6, exp_v, (s >= 6));
                n_err++;
            end
        end
        sb.push_back(16'h0000);
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        n_vec++;
        if (out_q6 !== exp_v) begin
            $display("FAIL num_in6_q sel=7 out_q=%h expected=%h", out_q6, exp_v); n_err++;
        end
    endtask

    task automatic test_full_width();
        @(negedge clk);
        for (int k = 0; k < 8; k++) in_w[k] = 16'hFFFF;
        in_w[0] = 16'h0000;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk) sel = (t % 2 == 0) ? 3'd7 : 3'd0;
            sb.push_back((t % 2 == 0) ? 16'hFFFF : 16'h0000);
            sb.push_back((t % 2 == 0) ? 16'hFFFF : 16'h0000);
            #1;
            exp_v = sb.pop_front();
            n_vec++;
            if (out !== exp_v) begin
                $display("FAIL full_width_out step=%0d out=%h expected=%h", t, out, exp_v); n_err++;
            end
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            n_vec++;
            if (out_q !== exp_v) begin
                $display("FAIL full_width_q step=%0d out_q=%h expected=%h", t, out_q, exp_v); n_err++;
            end
        end
    endtask

    task automatic test_x_sel();
        @(negedge clk) sel = 3'bxxx;
        #1;
        n_vec++;
        if (!(out === 16'h0000 || $isunknown(out))) begin
            $display("FAIL x_sel out=%h expected 0000 or unknown", out); n_err++;
        end
        sel = 3'd0;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_mid_cycle();
        test_reset_mid();
        test_in_change();
        test_num_in6();
        test_full_width();
        test_x_sel();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_leftover entries=%0d expected=0", sb.size()); n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rb_read_mux.md
Name: rb_read_mux

Overview:
- Register-bank read-port multiplexer: selects one of eight 16-bit register words by a 3-bit index.
- Drives the processor's operand/read bus.
- Provides a zero-latency combinational output plus a one-cycle registered copy for timing-critical consumers.
- Sits between the register bank storage and the ALU/datapath operand inputs.

Parameters:
- WIDTH, 16, data width of each input word and of the outputs.
- NUM_IN, 8, number of selectable inputs; legal range 2..8.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in0  input  WIDTH  register word 0.
- in1  input  WIDTH  register word 1.
- in2  input  WIDTH  register word 2.
- in3  input  WIDTH  register word 3.
- in4  input  WIDTH  register word 4.
- in5  input  WIDTH  register word 5.
- in6  input  WIDTH  register word 6.
- in7  input  WIDTH  register word 7.
- sel  input  SEL_W  read index.
- out  output  WIDTH  combinational selected word.
- out_q  output  WIDTH  registered selected word.
- sel_err  output  1  combinational flag: sel >= NUM_IN.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- out = in[sel], purely combinational with zero latency.
  - Any change on sel or on the selected input propagates in the same delta/time step.
  - out is not affected by rst_n.
- Encoding is binary and one-to-one: sel 0 selects in0, ..., sel 7 selects in7. No priority logic.
- Inputs at index >= NUM_IN are ignored (tie off unused ports).
- If sel >= NUM_IN: out = 0 and sel_err = 1. Otherwise sel_err = 0.
  - With the default NUM_IN = 8, sel_err is constant 0.
- Unknown or X sel: out must not silently select a word. X-propagation on out is acceptable; a default-to-zero is also acceptable.
- out_q captures out on each rising clk edge; latency is exactly 1 cycle.
- rst_n low clears out_q to 0 immediately, regardless of clk.
  - out_q holds 0 while reset is asserted.
  - The first capture occurs on the first rising edge after rst_n deasserts.
- Reset asserted mid-operation: out_q clears at once; out keeps tracking sel.
- sel changes between edges: only the value present at the edge is captured into out_q.
- No internal state other than the out_q register. No handshake. No enable.

Decomposition:
- Shared package rb_pkg:
  - RB_WIDTH = 16, RB_DEPTH = 8, RB_SEL_W = 3.
  - typedef rb_word_t (logic [RB_WIDTH-1:0]).
  - typedef rb_idx_t (logic [RB_SEL_W-1:0]).
- One natural sub-module, rb_mux_core: the pure combinational NUM_IN:1 selector with the sel_err flag.
- rb_read_mux wraps rb_mux_core and adds the out_q register with asynchronous reset.

Test Plan:
- Set in_k = k (in0 = 0x0000 ... in7 = 0x0007). Sweep sel 0..7, holding each value for 100 time units. Required: out = 0x0000, 0x0001, ..., 0x0007 immediately at each step; sel_err = 0 throughout.
- Same inputs, clock running. Change sel 2 -> 5 mid-cycle. Required: out = 0x0005 immediately; out_q = 0x0002 until the next rising edge, then 0x0005.
- Assert rst_n = 0 while out_q = 0x0005. Required: out_q = 0x0000 with no clock edge, and it stays 0 during reset; out = 0x0005 unchanged. Deassert reset: out_q = 0x0005 after the first edge.
- sel = 3; change in3 from 0x0003 to 0xBEEF. Required: out = 0xBEEF in the same time step; out_q = 0xBEEF after one edge. Changing a non-selected input such as in4 leaves out unchanged.
- NUM_IN = 6 configuration, sel = 6 or 7. Required: out = 0x0000, sel_err = 1. With sel = 5: out = in5, sel_err = 0.
- All inputs set to 0xFFFF except in0 = 0x0000. Toggle sel 0 <-> 7. Required: out alternates 0x0000 / 0xFFFF exactly, with no bit corruption across the full width.
